// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - shared constants and helpers for the round-robin crossbar
package crossbar_pkg;

  localparam int CB_PORTS = 4;
  localparam int CB_WIDTH = 8;
  localparam int STATS_W  = 16;

  // Pointer width for an N-way arbiter; never narrower than one bit.
  function automatic int clog2_ports(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin arbiter with registered rotating pointer
module rr_arbiter
  import crossbar_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic         ptr_upd
);

  localparam int PW = clog2_ports(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  logic [N-1:0]  w_gnt;
  logic          w_found;
  int            w_idx;

  // Search upward from the pointer, wrapping, and take the first requester.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_next  = r_ptr;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (en && req[w_idx] && !w_found) begin
        w_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_next       = (w_idx == N - 1) ? '0 : PW'(w_idx + 1);
      end
    end
  end

  assign gnt     = w_gnt;
  assign ptr_upd = w_found;

  // Pointer moves just past the winner; it only moves when a grant is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/crossbar_rr.sv
// rtl/crossbar_rr.sv - registered round-robin multicast crossbar (optional CB_STATS_EN stall counters)
module crossbar_rr
  import crossbar_pkg::*;
#(
  parameter int PORTS = CB_PORTS,
  parameter int WIDTH = CB_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            valid_i,
  input  logic [PORTS-1:0][PORTS-1:0] dest,
  input  logic [PORTS-1:0][WIDTH-1:0] data_i,
  output logic [PORTS-1:0][PORTS-1:0] ack,
  output logic [PORTS-1:0]            done,
  output logic [PORTS-1:0][WIDTH-1:0] data_o,
  output logic [PORTS-1:0]            valid_o,
  input  logic [PORTS-1:0]            ready_i
`ifdef CB_STATS_EN
  ,
  output logic [PORTS-1:0][STATS_W-1:0] stall_cnt
`endif
);

  logic [PORTS-1:0][PORTS-1:0] r_served;
  logic [PORTS-1:0][WIDTH-1:0] r_data_o;
  logic [PORTS-1:0]            r_valid_o;

  logic [PORTS-1:0][PORTS-1:0] w_pend;   // indexed [input][output]
  logic [PORTS-1:0][PORTS-1:0] w_req;    // indexed [output][input]
  logic [PORTS-1:0][PORTS-1:0] w_gnt;    // indexed [output][input]
  logic [PORTS-1:0]            w_upd;
  logic [PORTS-1:0]            w_free;
  logic [PORTS-1:0][PORTS-1:0] w_acked;  // per input, outputs that took it now
  logic [PORTS-1:0][WIDTH-1:0] w_sel;    // per output, winning input's flit

  // Outstanding destinations per input and their transpose as per-output requests.
  always_comb begin
    w_pend = '0;
    w_req  = '0;
    for (int i = 0; i < PORTS; i++) begin
      w_pend[i] = valid_i[i] ? (dest[i] & ~r_served[i]) : '0;
      for (int j = 0; j < PORTS; j++) begin
        w_req[j][i] = w_pend[i][j];
      end
    end
  end

  // An output can take a new flit when empty or being drained this cycle.
  always_comb begin
    for (int j = 0; j < PORTS; j++) begin
      w_free[j] = !r_valid_o[j] || ready_i[j];
    end
  end

  genvar gj;
  generate
    for (gj = 0; gj < PORTS; gj++) begin : g_arb
      rr_arbiter #(.N(PORTS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req[gj]),
        .en      (w_free[gj]),
        .gnt     (w_gnt[gj]),
        .ptr_upd (w_upd[gj])
      );
    end
  endgenerate

  // Fan grants back to inputs as ack/done and pick each output's winning flit.
  always_comb begin
    ack     = '0;
    done    = '0;
    w_acked = '0;
    w_sel   = '0;
    for (int i = 0; i < PORTS; i++) begin
      for (int j = 0; j < PORTS; j++) begin
        ack[i][j]     = rst_n && w_gnt[j][i];
        w_acked[i][j] = w_gnt[j][i];
        if (w_gnt[j][i]) w_sel[j] = w_sel[j] | data_i[i];
      end
      done[i] = rst_n && valid_i[i] && ((w_pend[i] & ~w_acked[i]) == '0);
    end
  end

  // Output register stage: load on grant, drop valid when drained with no grant, hold on backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_o  <= '0;
      r_valid_o <= '0;
    end else begin
      for (int j = 0; j < PORTS; j++) begin
        if (w_free[j]) begin
          if (w_upd[j]) begin
            r_data_o[j]  <= w_sel[j];
            r_valid_o[j] <= 1'b1;
          end else begin
            r_valid_o[j] <= 1'b0;
          end
        end
      end
    end
  end

  // Delivery tracking; an abandoned flit (valid dropped) forgets its partial progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_served <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (done[i] || !valid_i[i]) begin
          r_served[i] <= '0;
        end else begin
          r_served[i] <= r_served[i] | w_acked[i];
        end
      end
    end
  end

  assign data_o  = r_data_o;
  assign valid_o = r_valid_o;

`ifdef CB_STATS_EN
  logic [PORTS-1:0][STATS_W-1:0] r_stall_cnt;

  // Count cycles with contention or a blocked requester, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else begin
      for (int j = 0; j < PORTS; j++) begin
        if ((((w_req[j] & (w_req[j] - PORTS'(1))) != '0) ||
             ((w_req[j] != '0) && !w_free[j])) &&
            (r_stall_cnt[j] != {STATS_W{1'b1}})) begin
          r_stall_cnt[j] <= r_stall_cnt[j] + STATS_W'(1);
        end
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
